// File: rtl/inst_mem_loader_pkg.sv
// Shared types and defaults for the boot-time instruction memory loader.
package inst_mem_loader_pkg;

  localparam int unsigned MEM_WORDS_DEF = 256;
  localparam int unsigned TIMEOUT_DEF   = 1000000;
  localparam logic [7:0]  HDR_BYTE_DEF  = 8'hA5;
  localparam int unsigned WL_W          = 9;
  localparam int unsigned CNT_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    EC_NONE      = 2'd0,
    EC_BAD_COUNT = 2'd1,
    EC_CSUM      = 2'd2,
    EC_TIMEOUT   = 2'd3
  } err_code_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } imem_wr_t;

  // Word index to byte address; low two bits always zero.
  function automatic logic [31:0] word_addr(input logic [WL_W-1:0] idx);
    return {21'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/inst_mem_loader_timeout_ctr.sv
// Idle-cycle counter: runs while enabled, clears on each received byte, flags expiry.
module loader_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_c
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte in the expiry cycle suppresses the timeout.
  assign expire_c = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// Parses framed UART program images and writes big-endian words into instruction RAM.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = MEM_WORDS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            we,
  output logic [31:0]     waddr,
  output logic [31:0]     wdata,
  output logic            cpu_hold,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [WL_W-1:0] words_loaded
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WL_W-1:0]  words_q, words_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [23:0]      asm_q, asm_d;
  logic [7:0]       csum_q, csum_d;
  logic             we_q, we_d;
  imem_wr_t         wr_q, wr_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  err_code_e        ec_q, ec_d;

  logic             in_frame_c;
  logic             expire_c;
  logic [CNT_W-1:0] cnt_full_c;

  assign in_frame_c = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign cnt_full_c = {count_q[15:8], rx_data};

  loader_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (in_frame_c),
    .clr_i   (rx_valid),
    .expire_c(expire_c)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    words_d = words_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    wr_d    = wr_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    ec_d    = ec_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (rx_valid && (rx_data == HDR_BYTE)) begin
          state_d = ST_CNT_HI;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ec_d    = EC_NONE;
          words_d = '0;
          csum_d  = '0;
          bidx_d  = '0;
        end
      end
      ST_CNT_HI: begin
        if (rx_valid) begin
          count_d = {rx_data, count_q[7:0]};
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          count_d = cnt_full_c;
          if ((cnt_full_c == '0) || (cnt_full_c > CNT_W'(MEM_WORDS))) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            ec_d    = EC_BAD_COUNT;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // Write of word k is issued while word k+1 starts accumulating.
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          asm_d  = {asm_q[15:0], rx_data};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            we_d      = 1'b1;
            wr_d.addr = word_addr(words_q);
            wr_d.data = {asm_q, rx_data};
            words_d   = words_q + WL_W'(1);
            if ((CNT_W'(words_q) + CNT_W'(1)) == count_q) begin
              state_d = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            ec_d    = EC_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (expire_c) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      ec_d    = EC_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      words_q <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      wr_q    <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ec_q    <= EC_NONE;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      words_q <= words_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ec_q    <= ec_d;
    end
  end

  assign we           = we_q;
  assign waddr        = wr_q.addr;
  assign wdata        = wr_q.data;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = ec_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader; write pulses are scored against an expected queue.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [8:0]  words_loaded;

  int errors = 0;
  int checks = 0;
  int unexpected = 0;
  int wcount = 0;
  logic [63:0] exp_q[$];

  inst_mem_loader #(
    .MEM_WORDS     (256),
    .TIMEOUT_CYCLES(16),
    .HDR_BYTE      (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples outputs on the falling edge, scores any write, then drives the next input.
  task automatic tick(input logic v, input logic [7:0] d);
    logic [63:0] e;
    @(negedge clk);
    if (we === 1'b1) begin
      wcount++;
      if (exp_q.size() == 0) begin
        unexpected++;
      end else begin
        e = exp_q.pop_front();
        chk("waddr", waddr, e[63:32]);
        chk("wdata", wdata, e[31:0]);
      end
    end
    rx_valid = v;
    rx_data  = d;
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic frame_end(input string pfx);
    chk({pfx, ".pending_writes"}, 32'(exp_q.size()), 32'd0);
    chk({pfx, ".extra_we"}, 32'(unexpected), 32'd0);
    exp_q.delete();
    unexpected = 0;
  endtask

  task automatic check_state(input string pfx, input logic hold, input logic dn,
                             input logic er, input logic [1:0] ec, input logic [8:0] wl);
    chk({pfx, ".cpu_hold"}, 32'(cpu_hold), 32'(hold));
    chk({pfx, ".done"}, 32'(done), 32'(dn));
    chk({pfx, ".err"}, 32'(err), 32'(er));
    chk({pfx, ".err_code"}, 32'(err_code), 32'(ec));
    chk({pfx, ".words_loaded"}, 32'(words_loaded), 32'(wl));
  endtask

  task automatic check_zero(input string pfx);
    check_state(pfx, 1'b0, 1'b0, 1'b0, 2'd0, 9'd0);
    chk({pfx, ".we"}, 32'(we), 32'd0);
    chk({pfx, ".waddr"}, waddr, 32'd0);
    chk({pfx, ".wdata"}, wdata, 32'd0);
  endtask

  task automatic send_good(input logic [7:0] last);
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h08); send(8'h00); send(8'h00); send(8'h03);
    send(8'h3C); send(8'h08); send(8'h40); send(8'h00);
    send(last);
  endtask

  initial begin
    logic [7:0] kb;
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] cs;
    int w0;

    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check_zero("reset");
    reset = 1'b1;
    idle(2);

    // Noise in IDLE
    send(8'h00); send(8'hFF); send(8'h12);
    idle(2);
    check_state("noise_idle", 1'b0, 1'b0, 1'b0, 2'd0, 9'd0);
    frame_end("noise_idle");

    // Good two-word frame
    expect_wr(32'h0, 32'h08000003);
    expect_wr(32'h4, 32'h3C084000);
    send_good(8'h7F);
    idle(3);
    check_state("good", 1'b0, 1'b1, 1'b0, 2'd0, 9'd2);
    frame_end("good");

    // Noise while DONE leaves status alone
    send(8'h00); send(8'hFF);
    idle(2);
    check_state("noise_done", 1'b0, 1'b1, 1'b0, 2'd0, 9'd2);

    // Bad checksum: writes still happen
    expect_wr(32'h0, 32'h08000003);
    expect_wr(32'h4, 32'h3C084000);
    send_good(8'h7E);
    idle(3);
    check_state("bad_csum", 1'b1, 1'b0, 1'b1, 2'd2, 9'd2);
    frame_end("bad_csum");

    // Count 257 is rejected right after the third byte
    send(8'hA5); send(8'h01); send(8'h01);
    idle(1);
    check_state("cnt257", 1'b1, 1'b0, 1'b1, 2'd1, 9'd0);
    idle(2);
    frame_end("cnt257");

    // Count 0 is rejected
    send(8'hA5); send(8'h00); send(8'h00);
    idle(1);
    check_state("cnt0", 1'b1, 1'b0, 1'b1, 2'd1, 9'd0);
    idle(2);
    frame_end("cnt0");

    // Timeout fires on the 16th idle cycle, not before
    send(8'hA5); send(8'h00); send(8'h01); send(8'h08);
    idle(16);
    check_state("to_edge", 1'b1, 1'b0, 1'b0, 2'd0, 9'd0);
    idle(1);
    check_state("timeout", 1'b1, 1'b0, 1'b1, 2'd3, 9'd0);
    idle(2);
    frame_end("timeout");

    // Byte arriving exactly in the expiry cycle wins; frame then completes
    expect_wr(32'h0, 32'hDEADBEEF);
    send(8'hA5); send(8'h00); send(8'h01);
    idle(15);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h22);
    idle(3);
    check_state("late_byte", 1'b0, 1'b1, 1'b0, 2'd0, 9'd1);
    frame_end("late_byte");

    // Asynchronous reset during DATA
    send(8'hA5); send(8'h00); send(8'h01); send(8'h11); send(8'h22);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("mid_reset.hold_before", 32'(cpu_hold), 32'd1);
    #1 reset = 1'b0;
    #1 check_zero("mid_reset");
    idle(2);
    reset = 1'b1;
    idle(2);
    frame_end("mid_reset");

    expect_wr(32'h0, 32'h08000003);
    expect_wr(32'h4, 32'h3C084000);
    send_good(8'h7F);
    idle(3);
    check_state("after_reset", 1'b0, 1'b1, 1'b0, 2'd0, 9'd2);
    frame_end("after_reset");

    // Full-depth frame streamed with rx_valid every cycle
    w0 = wcount;
    cs = 8'h00;
    send(8'hA5); send(8'h01); send(8'h00);
    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      b0 = kb;
      b1 = kb ^ 8'hC3;
      b2 = ~kb;
      b3 = 8'(k * 7);
      cs = cs ^ b0 ^ b1 ^ b2 ^ b3;
      expect_wr(32'(k * 4), {b0, b1, b2, b3});
      send(b0); send(b1); send(b2); send(b3);
    end
    send(cs);
    idle(3);
    check_state("stream", 1'b0, 1'b1, 1'b0, 2'd0, 9'd256);
    chk("stream.we_pulses", 32'(wcount - w0), 32'd256);
    chk("stream.last_waddr", waddr, 32'h3FC);
    frame_end("stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Boot-time writer for the CPU's instruction store.
- Consumes a byte stream from the UART receiver (one-cycle rx_valid strobes) and parses a framed program image.
- Assembles big-endian 32-bit words and issues single-cycle writes to a writable instruction RAM at byte addresses 0, 4, 8, and so on.
- Holds the CPU in reset while loading and reports done or error.

Parameters:
- MEM_WORDS, 256, instruction memory depth in words; maximum accepted word count.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes inside a frame before abort.
- HDR_BYTE, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte
- rx_data  input  8  received byte
- we  output  1  instruction RAM write enable, one-cycle pulse per word
- waddr  output  32  byte address of the write (word index << 2, bits [1:0] = 0)
- wdata  output  32  word to write
- cpu_hold  output  1  keep CPU in reset while high
- done  output  1  level; last frame loaded with correct checksum
- err  output  1  level; last frame aborted
- err_code  output  2  0 none, 1 bad count, 2 checksum mismatch, 3 timeout
- words_loaded  output  9  words written in current or last frame

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; internal count, word index, byte index, checksum and timeout counter cleared.
- Frame format: HDR_BYTE, count high byte, count low byte, 4*N payload bytes (big-endian words, MSB first), then checksum byte.
- The checksum is the 8-bit XOR of all payload bytes only.
- States: IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR.
- IDLE, DONE and ERR:
  - Only rx_valid with rx_data==HDR_BYTE has effect.
  - It moves to CNT_HI, sets cpu_hold=1, clears done, err, err_code, words_loaded, checksum and index.
  - Other bytes are ignored.
- CNT_HI: the byte becomes N[15:8]; go to CNT_LO.
- CNT_LO: the byte becomes N[7:0].
  - If N==0 or N>MEM_WORDS: go to ERR with err_code=1.
  - Otherwise go to DATA.
- DATA:
  - Each byte shifts into a 32-bit assembly register (first byte lands in [31:24]) and is XORed into the checksum.
  - On the 4th byte of a word (accepted in cycle t), in cycle t+1: we=1 for exactly one cycle, waddr=index*4, wdata=assembled word; words_loaded and the index increment.
  - After word N-1 is accepted, go to CSUM.
- CSUM:
  - Byte equals checksum: go to DONE, done=1, cpu_hold=0.
  - Otherwise: go to ERR, err_code=2.
- ERR: err=1, cpu_hold stays 1 (corrupt image must not run). Words already written are not rolled back.
- Timeout:
  - In CNT_HI, CNT_LO, DATA and CSUM, a counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYCLES-1 with no byte goes to ERR with err_code=3.
  - A byte arriving in the expiry cycle wins; no timeout.
- Mid-frame header: HDR_BYTE inside a frame is treated as data or count, not a restart. Only timeout or completion ends a frame.
- Back-to-back rx_valid every cycle must be supported. The write of word k and the accumulation of word k+1 overlap without loss.
- Reset asserted mid-frame: immediate return to IDLE. The pending we is dropped and cpu_hold goes to 0.
- waddr never exceeds (MEM_WORDS-1)*4.

Decomposition:
- Shared package:
  - State encoding constants.
  - err_code values.
  - HDR_BYTE default.
  - MEM_WORDS, kept consistent with the instruction memory depth.
- One sub-module: loader_timeout_ctr, the parameterised idle counter with clear and expire outputs.
- Parsing and word assembly stay in the top module.

Test Plan:
- Good frame: A5 00 02 08 00 00 03 3C 08 40 00 7F.
  - Required: exactly two we pulses, (waddr 0x0, wdata 0x08000003) then (0x4, 0x3C084000).
  - Then done=1, cpu_hold=0, words_loaded=2, err=0.
- Bad checksum: same frame ending 7E.
  - Required: both writes occur, then err=1, err_code=2, cpu_hold=1, done=0.
- Bad count: A5 01 01.
  - Required: err_code=1 immediately after the third byte, no we pulse.
  - Also A5 00 00 gives err_code=1.
- Timeout: with TIMEOUT_CYCLES=16, send A5 00 01 08 then stall 16 cycles.
  - Required: err_code=3, no we.
  - A following valid frame loads correctly and clears err.
- Reset mid-frame: assert reset=0 during DATA after 2 payload bytes.
  - Required: all outputs 0 asynchronously, no we.
  - After release, a full good frame succeeds.
- Streaming and noise:
  - Noise bytes 00 FF 12 while in IDLE: no state change.
  - A 256-word frame with rx_valid every cycle writes waddr 0x0..0x3FC in order, 256 pulses, done=1.
